// File: rtl/rf_pkg.sv
// Register-file constants and the register-id type shared by the register file,
// decode and the dependency scoreboard.
package rf_pkg;
    localparam int REG_W    = 4;
    localparam int NUM_REGS = 16;

    typedef logic [REG_W-1:0] reg_id_t;

    localparam reg_id_t ZERO_REG = 4'd0;

    // R0 never takes part in dependency tracking, so any hit on it is dropped here.
    function automatic logic reg_hit(input logic valid, input reg_id_t id, input reg_id_t r);
        return valid && (id == r) && (id != ZERO_REG);
    endfunction
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/WB/flush-side signal bundle of the register-dependency scoreboard.
interface reg_scoreboard_if;
    import rf_pkg::*;

    logic    issue_valid;
    logic    issue_writes;
    reg_id_t issue_dst;
    logic    src1_used;
    logic    src2_used;
    reg_id_t src1;
    reg_id_t src2;
    logic    wb_valid;
    reg_id_t wb_dst;
    logic    kill_valid;
    reg_id_t kill_dst;
    logic    stall;
    logic    any_pending;
    logic    err;

    modport master (
        output issue_valid, issue_writes, issue_dst, src1_used, src2_used, src1, src2,
               wb_valid, wb_dst, kill_valid, kill_dst,
        input  stall, any_pending, err
    );

    modport slave (
        input  issue_valid, issue_writes, issue_dst, src1_used, src2_used, src1, src2,
               wb_valid, wb_dst, kill_valid, kill_dst,
        output stall, any_pending, err
    );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register outstanding-write counter: one increment and two decrements net
// together each cycle; a net result below zero saturates at 0 and pulses o_unf.
module sb_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec_a,
    input  logic          i_dec_b,
    output logic [CW-1:0] o_cnt,
    output logic          o_zero,
    output logic          o_unf
);
    logic [CW-1:0] r_cnt;
    logic [CW+1:0] w_next;

    // Two guard bits: the top bit is the sign of the netted result.
    always_comb begin
        w_next = {2'b00, r_cnt}
               + {{(CW+1){1'b0}}, i_inc}
               - {{(CW+1){1'b0}}, i_dec_a}
               - {{(CW+1){1'b0}}, i_dec_b};
    end

    assign o_unf  = w_next[CW+1];
    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (o_unf)
            r_cnt <= '0;
        else
            r_cnt <= w_next[CW-1:0];
    end
endmodule

// File: rtl/reg_scoreboard.sv
// Register-dependency scoreboard: counts in-flight writers per register and
// stalls decode on RAW hazards and on saturated WAW chains.
module reg_scoreboard
    import rf_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  bus
);
    localparam int            CW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    logic [NUM_REGS-1:0][CW-1:0] w_cnt;
    logic [NUM_REGS-1:0]         w_zero;
    logic [NUM_REGS-1:0]         w_unf;
    logic [NUM_REGS-1:0]         w_wb_hit;
    logic [NUM_REGS-1:0]         w_kill_hit;
    logic [NUM_REGS-1:0]         w_inc;
    logic [NUM_REGS-1:0]         w_eff_nz;
    logic                        w_raw;
    logic                        w_waw_sat;
    logic                        w_stall;
    logic                        w_accept;
    logic                        r_err;

    genvar r;
    generate
        for (r = 0; r < NUM_REGS; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign w_cnt[r]      = '0;
                assign w_zero[r]     = 1'b1;
                assign w_unf[r]      = 1'b0;
                assign w_wb_hit[r]   = 1'b0;
                assign w_kill_hit[r] = 1'b0;
                assign w_inc[r]      = 1'b0;
            end else begin : g_cnt
                assign w_wb_hit[r]   = reg_hit(bus.wb_valid, bus.wb_dst, reg_id_t'(r));
                assign w_kill_hit[r] = reg_hit(bus.kill_valid, bus.kill_dst, reg_id_t'(r));
                assign w_inc[r]      = reg_hit(w_accept && bus.issue_writes, bus.issue_dst,
                                               reg_id_t'(r));

                sb_counter #(.CW(CW)) u_cnt (
                    .clk     (clk),
                    .rst     (rst),
                    .i_inc   (w_inc[r]),
                    .i_dec_a (w_wb_hit[r]),
                    .i_dec_b (w_kill_hit[r]),
                    .o_cnt   (w_cnt[r]),
                    .o_zero  (w_zero[r]),
                    .o_unf   (w_unf[r])
                );
            end
            // cnt - wb_hit is non-zero exactly when the two differ; only WB earns bypass credit.
            assign w_eff_nz[r] = (w_cnt[r] != {{(CW-1){1'b0}}, w_wb_hit[r]});
        end
    endgenerate

    assign w_raw     = (bus.src1_used && w_eff_nz[bus.src1])
                    || (bus.src2_used && w_eff_nz[bus.src2]);
    // Uses the registered count, so a same-cycle WB does not open a slot.
    assign w_waw_sat = bus.issue_writes && (bus.issue_dst != ZERO_REG)
                    && (w_cnt[bus.issue_dst] == MAX_CNT);
    assign w_stall   = bus.issue_valid && (w_raw || w_waw_sat) && !rst;
    assign w_accept  = bus.issue_valid && !w_stall && !rst;

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (|w_unf)
            r_err <= 1'b1;
    end

    assign bus.stall       = w_stall;
    assign bus.any_pending = ~&w_zero;
    assign bus.err         = r_err;
endmodule
